// File: rtl/time_set_ctrl.sv
// time_set_ctrl: user interface for setting the HH:MM:SS clock.
//
// Takes single-cycle debounced button pulses. A write pulse in IDLE copies
// the running time into shadow registers and enters EDIT. Select pulses move
// between the fields and value pulses change the selected field with
// wrap-around. A second write pulse goes to COMMIT, which raises o_load for
// exactly one cycle so the timekeeper takes o_set_*. EDIT is abandoned without
// a load when TIMEOUT_TICKS i_ena ticks pass with no button activity.
//
// Ports:
//   i_clk            system clock
//   i_rst            synchronous active-high reset
//   i_ena            single-cycle tick strobe (timeout and blink timing)
//   i_wr_pulse       enter edit mode / commit
//   i_val_inc_pulse  selected field +1
//   i_val_dec_pulse  selected field -1
//   i_sel_inc_pulse  next field
//   i_sel_dec_pulse  previous field
//   i_cur_hh/mm/ss   running time from the timekeeper (binary)
//   o_load           one-cycle load strobe to the timekeeper
//   o_set_hh/mm/ss   shadow time being edited
//   o_editing        high in EDIT and COMMIT
//   o_sel            selected field: 0 = HH, 1 = MM, 2 = SS
//   o_blink          blink phase of the selected field, 1 = visible

module time_set_ctrl #(
    parameter int TIMEOUT_TICKS = 10000,
    parameter int BLINK_TICKS   = 250
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ena,
    input  logic       i_wr_pulse,
    input  logic       i_val_inc_pulse,
    input  logic       i_val_dec_pulse,
    input  logic       i_sel_inc_pulse,
    input  logic       i_sel_dec_pulse,
    input  logic [4:0] i_cur_hh,
    input  logic [5:0] i_cur_mm,
    input  logic [5:0] i_cur_ss,
    output logic       o_load,
    output logic [4:0] o_set_hh,
    output logic [5:0] o_set_mm,
    output logic [5:0] o_set_ss,
    output logic       o_editing,
    output logic [1:0] o_sel,
    output logic       o_blink
);

    localparam int TO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam int BL_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_TICKS - 1);
    localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EDIT   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]      state;
    logic [TO_W-1:0] to_cnt;
    logic [BL_W-1:0] bl_cnt;
    logic            any_btn;

    assign any_btn = i_sel_inc_pulse | i_sel_dec_pulse |
                     i_val_inc_pulse | i_val_dec_pulse;

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
        return (v == 6'd0 || v > max) ? max : v - 6'd1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            o_load    <= 1'b0;
            o_editing <= 1'b0;
            o_sel     <= 2'd0;
            o_blink   <= 1'b0;
            o_set_hh  <= '0;
            o_set_mm  <= '0;
            o_set_ss  <= '0;
            to_cnt    <= '0;
            bl_cnt    <= '0;
        end else begin
            o_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_wr_pulse) begin
                        // Out-of-range time from the timekeeper is clamped to 0
                        o_set_hh  <= (i_cur_hh > 5'd23) ? 5'd0 : i_cur_hh;
                        o_set_mm  <= (i_cur_mm > 6'd59) ? 6'd0 : i_cur_mm;
                        o_set_ss  <= (i_cur_ss > 6'd59) ? 6'd0 : i_cur_ss;
                        o_sel     <= 2'd0;
                        o_blink   <= 1'b1;
                        o_editing <= 1'b1;
                        to_cnt    <= '0;
                        bl_cnt    <= '0;
                        state     <= S_EDIT;
                    end
                end

                S_EDIT: begin
                    if (i_wr_pulse || any_btn) begin
                        // Any honoured button restarts timeout and shows the field
                        to_cnt  <= '0;
                        bl_cnt  <= '0;
                        o_blink <= 1'b1;
                        if (i_wr_pulse) begin
                            o_load <= 1'b1;
                            state  <= S_COMMIT;
                        end else if (i_sel_inc_pulse) begin
                            o_sel <= (o_sel == 2'd2) ? 2'd0 : o_sel + 2'd1;
                        end else if (i_sel_dec_pulse) begin
                            o_sel <= (o_sel == 2'd0) ? 2'd2 : o_sel - 2'd1;
                        end else if (i_val_inc_pulse) begin
                            case (o_sel)
                                2'd0:    o_set_hh <= 5'(wrap_inc({1'b0, o_set_hh}, 6'd23));
                                2'd1:    o_set_mm <= wrap_inc(o_set_mm, 6'd59);
                                default: o_set_ss <= wrap_inc(o_set_ss, 6'd59);
                            endcase
                        end else begin
                            case (o_sel)
                                2'd0:    o_set_hh <= 5'(wrap_dec({1'b0, o_set_hh}, 6'd23));
                                2'd1:    o_set_mm <= wrap_dec(o_set_mm, 6'd59);
                                default: o_set_ss <= wrap_dec(o_set_ss, 6'd59);
                            endcase
                        end
                    end else if (i_ena) begin
                        if (to_cnt == TO_LAST) begin
                            // Inactivity: drop the edit, shadow left as it was
                            state     <= S_IDLE;
                            o_editing <= 1'b0;
                            o_blink   <= 1'b0;
                            to_cnt    <= '0;
                            bl_cnt    <= '0;
                        end else begin
                            to_cnt <= to_cnt + TO_ONE;
                            if (bl_cnt == BL_LAST) begin
                                bl_cnt  <= '0;
                                o_blink <= ~o_blink;
                            end else begin
                                bl_cnt <= bl_cnt + BL_ONE;
                            end
                        end
                    end
                end

                S_COMMIT: begin
                    state     <= S_IDLE;
                    o_editing <= 1'b0;
                    o_blink   <= 1'b0;
                end

                default: begin
                    state     <= S_IDLE;
                    o_editing <= 1'b0;
                    o_blink   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl (TIMEOUT_TICKS=8, BLINK_TICKS=2).
// The driver applies one input vector per clock on the falling edge and
// queues the hand-computed output expected after the following rising edge;
// the monitor pops one entry per rising edge and compares.

module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_ena = 1'b0;
    logic       i_wr_pulse = 1'b0;
    logic       i_val_inc_pulse = 1'b0;
    logic       i_val_dec_pulse = 1'b0;
    logic       i_sel_inc_pulse = 1'b0;
    logic       i_sel_dec_pulse = 1'b0;
    logic [4:0] i_cur_hh = '0;
    logic [5:0] i_cur_mm = '0;
    logic [5:0] i_cur_ss = '0;
    logic       o_load;
    logic [4:0] o_set_hh;
    logic [5:0] o_set_mm;
    logic [5:0] o_set_ss;
    logic       o_editing;
    logic [1:0] o_sel;
    logic       o_blink;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .TIMEOUT_TICKS(8),
        .BLINK_TICKS  (2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_ena          (i_ena),
        .i_wr_pulse     (i_wr_pulse),
        .i_val_inc_pulse(i_val_inc_pulse),
        .i_val_dec_pulse(i_val_dec_pulse),
        .i_sel_inc_pulse(i_sel_inc_pulse),
        .i_sel_dec_pulse(i_sel_dec_pulse),
        .i_cur_hh       (i_cur_hh),
        .i_cur_mm       (i_cur_mm),
        .i_cur_ss       (i_cur_ss),
        .o_load         (o_load),
        .o_set_hh       (o_set_hh),
        .o_set_mm       (o_set_mm),
        .o_set_ss       (o_set_ss),
        .o_editing      (o_editing),
        .o_sel          (o_sel),
        .o_blink        (o_blink)
    );

    typedef struct {
        logic [21:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;

    logic [4:0] nhh = '0;
    logic [5:0] nmm = '0;
    logic [5:0] nss = '0;

    localparam logic [4:0] B_NONE = 5'd0;
    localparam logic [4:0] B_WR   = 5'd1;
    localparam logic [4:0] B_SI   = 5'd2;
    localparam logic [4:0] B_SD   = 5'd4;
    localparam logic [4:0] B_VI   = 5'd8;
    localparam logic [4:0] B_VD   = 5'd16;

    // Packed expectation: {load, editing, sel[1:0], blink, hh[4:0], mm[5:0], ss[5:0]}
    function automatic logic [21:0] ex(input logic ld, input logic ed, input logic [1:0] sel,
                                       input logic bl, input logic [4:0] hh,
                                       input logic [5:0] mm, input logic [5:0] ss);
        return {ld, ed, sel, bl, hh, mm, ss};
    endfunction

    task automatic cyc(input logic [4:0] b, input logic ena, input logic rst,
                       input logic [21:0] e, input string nm);
        item_t it;
        @(negedge clk);
        i_wr_pulse      = b[0];
        i_sel_inc_pulse = b[1];
        i_sel_dec_pulse = b[2];
        i_val_inc_pulse = b[3];
        i_val_dec_pulse = b[4];
        i_ena           = ena;
        i_rst           = rst;
        i_cur_hh        = nhh;
        i_cur_mm        = nmm;
        i_cur_ss        = nss;
        it.exp  = e;
        it.name = nm;
        sb.push_back(it);
    endtask

    // Monitor
    initial begin
        item_t       it;
        logic [21:0] act;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                it  = sb.pop_front();
                act = {o_load, o_editing, o_sel, o_blink, o_set_hh, o_set_mm, o_set_ss};
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got ld=%0b ed=%0b sel=%0d bl=%0b %0d:%0d:%0d, expected ld=%0b ed=%0b sel=%0d bl=%0b %0d:%0d:%0d",
                             it.name, act[21], act[20], act[19:18], act[17], act[16:12], act[11:6], act[5:0],
                             it.exp[21], it.exp[20], it.exp[19:18], it.exp[17], it.exp[16:12],
                             it.exp[11:6], it.exp[5:0]);
                end
            end
        end
    end

    // Driver
    initial begin
        logic bl;

        cyc(B_NONE, 0, 1, ex(0, 0, 0, 0, 0, 0, 0), "reset0");
        cyc(B_NONE, 0, 1, ex(0, 0, 0, 0, 0, 0, 0), "reset1");

        // Enter and exit
        nhh = 5'd12; nmm = 6'd34; nss = 6'd56;
        cyc(B_WR,   0, 0, ex(0, 1, 0, 1, 12, 34, 56), "enter");
        cyc(B_NONE, 0, 0, ex(0, 1, 0, 1, 12, 34, 56), "edit_hold");
        cyc(B_WR,   0, 0, ex(1, 1, 0, 1, 12, 34, 56), "commit");
        nhh = 5'd3; nmm = 6'd4; nss = 6'd5;
        cyc(B_NONE, 0, 0, ex(0, 0, 0, 0, 12, 34, 56), "exit");
        cyc(B_NONE, 0, 0, ex(0, 0, 0, 0, 12, 34, 56), "idle_hold");

        // Wraps
        nhh = 5'd23; nmm = 6'd59; nss = 6'd59;
        cyc(B_WR, 0, 0, ex(0, 1, 0, 1, 23, 59, 59), "enter2");
        cyc(B_VI, 0, 0, ex(0, 1, 0, 1, 0, 59, 59),  "hh_wrap");
        cyc(B_SD, 0, 0, ex(0, 1, 2, 1, 0, 59, 59),  "sel_dec_wrap");
        cyc(B_VI, 0, 0, ex(0, 1, 2, 1, 0, 59, 0),   "ss_wrap");
        cyc(B_VD, 0, 0, ex(0, 1, 2, 1, 0, 59, 59),  "ss_dec_wrap");
        cyc(B_VD, 0, 0, ex(0, 1, 2, 1, 0, 59, 58),  "ss_dec");
        cyc(B_SD, 0, 0, ex(0, 1, 1, 1, 0, 59, 58),  "sel_dec_1");
        cyc(B_SD, 0, 0, ex(0, 1, 0, 1, 0, 59, 58),  "sel_dec_0");

        // Select cycling
        cyc(B_SI, 0, 0, ex(0, 1, 1, 1, 0, 59, 58), "sel_inc_1");
        cyc(B_SI, 0, 0, ex(0, 1, 2, 1, 0, 59, 58), "sel_inc_2");
        cyc(B_SI, 0, 0, ex(0, 1, 0, 1, 0, 59, 58), "sel_inc_0");
        cyc(B_SI, 0, 0, ex(0, 1, 1, 1, 0, 59, 58), "sel_inc_1b");

        // Priority
        cyc(B_VI | B_SI, 0, 0, ex(0, 1, 2, 1, 0, 59, 58), "prio_sel_over_val");
        cyc(B_SD,        0, 0, ex(0, 1, 1, 1, 0, 59, 58), "sel_dec_mm");
        cyc(B_VI,        0, 0, ex(0, 1, 1, 1, 0, 0, 58),  "mm_wrap");
        cyc(B_VD,        0, 0, ex(0, 1, 1, 1, 0, 59, 58), "mm_dec_wrap");
        cyc(B_WR | B_VI, 0, 0, ex(1, 1, 1, 1, 0, 59, 58), "commit2_prio");
        cyc(B_VI,        0, 0, ex(0, 0, 1, 0, 0, 59, 58), "commit_ignores");
        cyc(B_VI,        0, 0, ex(0, 0, 1, 0, 0, 59, 58), "idle_ignore_val");
        cyc(B_SI | B_SD | B_VD, 0, 0, ex(0, 0, 1, 0, 0, 59, 58), "idle_ignore_all");

        // Clamp
        nhh = 5'd27; nmm = 6'd60; nss = 6'd56;
        cyc(B_WR,   0, 0, ex(0, 1, 0, 1, 0, 0, 56), "clamp");
        cyc(B_WR,   0, 0, ex(1, 1, 0, 1, 0, 0, 56), "commit3");
        cyc(B_NONE, 0, 0, ex(0, 0, 0, 0, 0, 0, 56), "exit3");

        // Timeout and blink, tick every 4 clocks
        nhh = 5'd1; nmm = 6'd2; nss = 6'd3;
        cyc(B_WR, 0, 0, ex(0, 1, 0, 1, 1, 2, 3), "enter_to");
        for (int k = 1; k <= 7; k++) begin
            bl = ((k / 2) % 2) == 0;
            cyc(B_NONE, 1, 0, ex(0, 1, 0, bl, 1, 2, 3), "tick_a");
            for (int j = 0; j < 3; j++) cyc(B_NONE, 0, 0, ex(0, 1, 0, bl, 1, 2, 3), "between_a");
        end
        cyc(B_VI, 1, 0, ex(0, 1, 0, 1, 2, 2, 3), "tick_vs_button");
        for (int j = 0; j < 3; j++) cyc(B_NONE, 0, 0, ex(0, 1, 0, 1, 2, 2, 3), "after_button");
        for (int k = 1; k <= 7; k++) begin
            bl = ((k / 2) % 2) == 0;
            cyc(B_NONE, 1, 0, ex(0, 1, 0, bl, 2, 2, 3), "tick_b");
            for (int j = 0; j < 3; j++) cyc(B_NONE, 0, 0, ex(0, 1, 0, bl, 2, 2, 3), "between_b");
        end
        cyc(B_NONE, 1, 0, ex(0, 0, 0, 0, 2, 2, 3), "timeout");
        for (int j = 0; j < 3; j++) cyc(B_NONE, 0, 0, ex(0, 0, 0, 0, 2, 2, 3), "timeout_idle");

        // Reset mid-edit together with write
        nhh = 5'd5; nmm = 6'd6; nss = 6'd7;
        cyc(B_WR,   0, 0, ex(0, 1, 0, 1, 5, 6, 7), "enter_rst");
        cyc(B_WR,   0, 1, ex(0, 0, 0, 0, 0, 0, 0), "rst_mid_edit");
        cyc(B_NONE, 0, 0, ex(0, 0, 0, 0, 0, 0, 0), "after_rst");
        cyc(B_NONE, 0, 0, ex(0, 0, 0, 0, 0, 0, 0), "after_rst2");

        // Drain the scoreboard
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #5;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Consumes the single-cycle debounced button pulses (write, value inc/dec, select inc/dec) and runs the time-set user interface for the HH:MM:SS clock.
- On entry it snapshots the running time into shadow registers. Buttons then edit the selected field with wrap-around.
- A commit issues a one-cycle load strobe to the timekeeper.
- Provides field-select and blink outputs so the display stage can flash the field being edited.

Parameters:
- TIMEOUT_TICKS, 10000: number of i_ena ticks with no button activity before edit mode is abandoned (10 s at a 1 kHz tick).
- BLINK_TICKS, 250: number of i_ena ticks per half-period of o_blink.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_ena  in  1  single-cycle tick strobe; the same strobe that drives the debouncers.
- i_wr_pulse  in  1  debounced write pulse: enters edit mode, or commits from it.
- i_val_inc_pulse  in  1  increments the selected field.
- i_val_dec_pulse  in  1  decrements the selected field.
- i_sel_inc_pulse  in  1  moves to the next field.
- i_sel_dec_pulse  in  1  moves to the previous field.
- i_cur_hh  in  5  current hours from the timekeeper, binary 0-23.
- i_cur_mm  in  6  current minutes, binary 0-59.
- i_cur_ss  in  6  current seconds, binary 0-59.
- o_load  out  1  one-cycle strobe; the timekeeper loads o_set_* when it is high.
- o_set_hh  out  5  shadow hours.
- o_set_mm  out  6  shadow minutes.
- o_set_ss  out  6  shadow seconds.
- o_editing  out  1  high while in EDIT.
- o_sel  out  2  selected field: 0 = HH, 1 = MM, 2 = SS; the value 3 is never produced.
- o_blink  out  1  blink phase for the selected field; 1 = field visible.

Behaviour:
- All outputs are registered.
- Reset (i_rst high at a rising edge):
  - state goes to IDLE;
  - o_load=0, o_editing=0, o_sel=0, o_blink=0;
  - o_set_hh/mm/ss=0;
  - timeout and blink counters clear.
- Reset takes priority over all other inputs. A reset during EDIT or COMMIT discards the edit; no o_load is issued.
- Input pulses are sampled on every i_clk edge, independent of i_ena. Each pulse acts once.
- A pulse sampled at edge N has its effect visible after edge N (registered, latency 1).
- State machine:
  - IDLE:
    - Only i_wr_pulse is honoured; all other pulses are ignored.
    - On i_wr_pulse: shadow <- i_cur_*. Any input value out of range (hh>23, mm/ss>59) is clamped to 0.
    - Also on i_wr_pulse: o_sel<=0, o_blink<=1, counters clear, go to EDIT.
  - EDIT: at most one action per cycle, in priority order wr > sel_inc > sel_dec > val_inc > val_dec. Lower-priority pulses in the same cycle are dropped.
    - wr: go to COMMIT.
    - sel_inc: o_sel goes 0->1->2->0.
    - sel_dec: o_sel goes 0->2->1->0.
    - val_inc: selected field +1. HH wraps 23->0; MM/SS wrap 59->0. The other fields are unchanged.
    - val_dec: selected field -1. HH wraps 0->23; MM/SS wrap 0->59.
    - Any honoured pulse clears the timeout counter and sets o_blink=1 with the blink counter at 0, so the edited field is shown immediately.
    - On i_ena without a button: the timeout counter increments. When i_ena arrives with the counter at TIMEOUT_TICKS-1, go to IDLE with no o_load and the shadow registers unchanged.
    - A button pulse in the same cycle as the timeout tick wins, and the timeout counter clears.
    - On i_ena the blink counter increments. At BLINK_TICKS-1 it wraps to 0 and o_blink toggles.
  - COMMIT:
    - Lasts exactly one cycle with o_load=1; next state is IDLE.
    - All pulses in this cycle are ignored.
    - o_set_* are stable during and after o_load.
- In EDIT and COMMIT, o_editing=1; in IDLE, o_editing=0.
- In IDLE, o_blink=0 and o_sel holds its last value.
- o_load is high only in COMMIT, never two consecutive cycles.
- Counters are sized by $clog2 of their parameter and must never overflow.

Test Plan:
- Enter and exit: i_cur=12:34:56, pulse wr, pulse wr.
  - After the first pulse: o_editing=1, o_set=12:34:56, o_sel=0.
  - After the second pulse: o_load high exactly 1 cycle with 12:34:56, then o_editing=0.
- Wrap, hours: enter with 23:59:59, then val_inc x1 -> o_set_hh=0.
- Wrap, seconds: sel_dec x1 -> o_sel=2; val_inc x1 -> o_set_ss=0, o_set_mm stays 59.
- Wrap, decrement: val_dec x2 from ss=0 -> ss=58.
- Select cycling and clamp:
  - sel_inc x4 from 0 -> o_sel sequence 1,2,0,1;
  - enter with i_cur_hh=27 -> o_set_hh=0.
- Priority and ignore: in EDIT, assert val_inc and sel_inc in the same cycle -> o_sel advances and the value is unchanged.
  - In IDLE, val_inc alone -> no state change.
- Timeout (TIMEOUT_TICKS=8, BLINK_TICKS=2, i_ena every 4 clocks):
  - 7 ticks, then val_inc -> stays in EDIT;
  - then 8 idle ticks -> returns to IDLE, o_load never asserted;
  - o_blink toggles every 2 ticks while editing.
- Reset mid-edit: assert i_rst while in EDIT, in the same cycle as wr -> all outputs at reset values, no o_load pulse.
